// File: rtl/gs_stim_gen_if.sv
// gs_stim_gen_if: start/busy/done control, a/b/valid stimulus and y feedback
// bundle between the stimulus sequencer and its host / gate under test.
interface gs_stim_gen_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             mode;
   logic [7:0]       seed;
   logic [CNT_W-1:0] n_vec;
   logic             a;
   logic             b;
   logic             valid;
   logic             y;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] vec_count;
   logic [CNT_W-1:0] err_count;
   logic             err;

   modport master (
      input  start, mode, seed, n_vec, y,
      output a, b, valid, busy, done, vec_count, err_count, err
   );

   modport slave (
      output start, mode, seed, n_vec, y,
      input  a, b, valid, busy, done, vec_count, err_count, err
   );
endinterface

// File: rtl/gs_stim_gen.sv
// gs_stim_gen: exhaustive/LFSR a,b stimulus sequencer for a 2-input gate.
// Optional NAND response checker enabled by defining GS_STIM_CHECK_EN.
module gs_stim_gen #(
   parameter int HOLD_CYCLES = 5,
   parameter int CNT_W       = 8
) (
   input  logic          clk,
   input  logic          rst,
   gs_stim_gen_if.master bus
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_DONE
   } state_t;

   state_t           state_q;
   logic             a_q;
   logic             b_q;
   logic             valid_q;
   logic             busy_q;
   logic             done_q;
   logic             mode_q;
   logic [7:0]       lfsr_q;
   logic [7:0]       lfsr_d;
   logic [CNT_W-1:0] nvec_q;
   logic [CNT_W-1:0] vec_q;
   logic [CNT_W-1:0] vec_d;
   logic [HW-1:0]    hold_q;

   assign lfsr_d = {lfsr_q[6:0],
                    lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign vec_d  = vec_q + 1'b1;

`ifdef GS_STIM_CHECK_EN
   logic [CNT_W-1:0] err_cnt_q;
   logic             err_q;
   logic             mis;

   assign mis = bus.y != ~(a_q & b_q);
   assign bus.err_count = err_cnt_q;
   assign bus.err       = err_q;
`else
   logic unused_y;

   assign unused_y      = bus.y;
   assign bus.err_count = '0;
   assign bus.err       = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= 1'b0;
         b_q       <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         mode_q    <= 1'b0;
         lfsr_q    <= 8'h01;
         nvec_q    <= '0;
         vec_q     <= '0;
         hold_q    <= '0;
`ifdef GS_STIM_CHECK_EN
         err_cnt_q <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  mode_q <= bus.mode;
                  nvec_q <= bus.n_vec;
                  lfsr_q <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
                  vec_q  <= '0;
`ifdef GS_STIM_CHECK_EN
                  err_cnt_q <= '0;
                  err_q     <= 1'b0;
`endif
                  if (bus.n_vec == '0) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     busy_q  <= 1'b1;
                     state_q <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               a_q     <= mode_q ? lfsr_q[1] : vec_q[1];
               b_q     <= mode_q ? lfsr_q[0] : vec_q[0];
               valid_q <= 1'b1;
               hold_q  <= HOLD_INIT;
               state_q <= S_HOLD;
            end
            S_HOLD: begin
               if (hold_q == '0) begin
                  vec_q   <= vec_d;
                  lfsr_q  <= lfsr_d;
                  valid_q <= 1'b0;
`ifdef GS_STIM_CHECK_EN
                  if (mis) begin
                     err_q <= 1'b1;
                     if (err_cnt_q != '1)
                        err_cnt_q <= err_cnt_q + 1'b1;
                  end
`endif
                  if (vec_d == nvec_q) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_LOAD;
                  end
               end else begin
                  hold_q <= hold_q - 1'b1;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.valid     = valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.vec_count = vec_q;

endmodule

// File: tb/tb_gs_stim_gen.sv
// tb_gs_stim_gen: table, hand-written and random runs of gs_stim_gen
// checked against a vector-list model built from the sequencing rules.
module tb_gs_stim_gen;

   localparam int HOLD  = 5;
   localparam int CNT_W = 8;
`ifdef GS_STIM_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk;
   logic rst;
   bit   and_mode;
   int   checks;
   int   failures;
   logic [1:0] got_q[$];

   gs_stim_gen_if #(.CNT_W(CNT_W)) bus ();

   gs_stim_gen #(
      .HOLD_CYCLES(HOLD),
      .CNT_W      (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   assign bus.y = and_mode ? (bus.a & bus.b) : ~(bus.a & bus.b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit               mode;
      logic [7:0]       seed;
      logic [CNT_W-1:0] n;
      bit               bad;
      bit               poke;
      bit               use_ab;
      logic [0:7][1:0]  ab;
      int               exp_vc;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], ^(l & 8'b1011_1000)};
   endfunction

   task automatic run(input string nm, input bit m, input logic [7:0] s,
                      input logic [CNT_W-1:0] n, input bit bad,
                      input bit poke);
      logic [7:0] l;
      logic [1:0] exp_q[$];
      logic [1:0] last;
      int cyc, first, rl, gap, lenbad, unstab, gapbad, done_cyc, budget;
      int exp_err, abbad;
      bit fin;
      l = (s == 8'h00) ? 8'h01 : s;
      for (int i = 0; i < int'(n); i++) begin
         exp_q.push_back(m ? l[1:0] : 2'(i % 4));
         l = lfsr_next(l);
      end
      exp_err = (CHK && bad) ? int'(n) : 0;
      got_q.delete();
      and_mode = bad;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = m; bus.seed = s; bus.n_vec = n;
      @(negedge clk);
      bus.start = 1'b0; bus.mode = ~m; bus.seed = 8'h5A; bus.n_vec = n + 3;
      cyc = 1; first = -1; rl = 0; gap = 0; lenbad = 0; unstab = 0;
      gapbad = 0; done_cyc = -1; fin = 0; last = 2'b00;
      budget = (int'(n) + 2) * (HOLD + 1) + 8;
      if (n != '0) chk({nm, " busy_at_load"}, bus.busy, 1);
      while (!fin && cyc <= budget) begin
         bus.start = (poke && cyc == 3);
         if (bus.valid) begin
            if (rl == 0) begin
               got_q.push_back({bus.a, bus.b});
               if (first < 0) first = cyc;
               else if (gap != 1) gapbad++;
            end else if ({bus.a, bus.b} != last) begin
               unstab++;
            end
            last = {bus.a, bus.b};
            rl++;
         end else begin
            if (rl > 0) begin
               if (rl != HOLD) lenbad++;
               gap = 0;
            end
            gap++;
            rl = 0;
         end
         if (bus.done) begin
            fin = 1;
            done_cyc = cyc;
            chk({nm, " busy_at_done"}, bus.busy, 0);
            chk({nm, " valid_at_done"}, bus.valid, 0);
            chk({nm, " vec_count"}, bus.vec_count, n);
            chk({nm, " err_count"}, bus.err_count, exp_err);
            chk({nm, " err"}, bus.err, exp_err != 0);
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      bus.start = 1'b0;
      if (!fin) chk({nm, " timeout_done"}, 0, 1);
      chk({nm, " done_cycle"}, done_cyc,
          (n == '0) ? 1 : int'(n) * (HOLD + 1) + 1);
      @(negedge clk);
      chk({nm, " done_pulse_width"}, bus.done, 0);
      chk({nm, " first_valid"}, first, (n == '0) ? -1 : 2);
      chk({nm, " hold_len_errs"}, lenbad, 0);
      chk({nm, " unstable_errs"}, unstab, 0);
      chk({nm, " gap_errs"}, gapbad, 0);
      chk({nm, " n_vectors"}, got_q.size(), exp_q.size());
      abbad = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] != exp_q[i]) abbad++;
      chk({nm, " ab_model_errs"}, abbad, 0);
   endtask

   initial begin
      int vcnt;
      checks = 0; failures = 0; and_mode = 1'b0;
      bus.start = 1'b0; bus.mode = 1'b0; bus.seed = 8'h00; bus.n_vec = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset outputs",
          {bus.a, bus.b, bus.valid, bus.busy, bus.done, bus.err}, 0);
      chk("reset vec_count", bus.vec_count, 0);
      chk("reset err_count", bus.err_count, 0);
      rst = 1'b0;

      tbl[0] = '{0, 8'h00, 4, 0, 0, 1, {2'b00, 2'b01, 2'b10, 2'b11,
                 2'b00, 2'b00, 2'b00, 2'b00}, 4};
      tbl[1] = '{1, 8'h00, 5, 0, 0, 1, {2'b01, 2'b10, 2'b00, 2'b00,
                 2'b01, 2'b00, 2'b00, 2'b00}, 5};
      tbl[2] = '{0, 8'h00, 0, 0, 0, 0, '0, 0};
      tbl[3] = '{0, 8'h00, 4, 1, 0, 0, '0, 4};
      tbl[4] = '{1, 8'hA5, 7, 1, 1, 0, '0, 7};
      tbl[5] = '{0, 8'h00, 6, 0, 1, 1, {2'b00, 2'b01, 2'b10, 2'b11,
                 2'b00, 2'b01, 2'b00, 2'b00}, 6};
      tbl[6] = '{0, 8'h00, 1, 0, 0, 1, '0, 1};

      for (int t = 0; t < 7; t++) begin
         run($sformatf("tbl%0d", t), tbl[t].mode, tbl[t].seed, tbl[t].n,
             tbl[t].bad, tbl[t].poke);
         chk($sformatf("tbl%0d final_vec_count", t), bus.vec_count,
             tbl[t].exp_vc);
         if (tbl[t].use_ab)
            for (int i = 0; i < got_q.size() && i < 8; i++)
               chk($sformatf("tbl%0d ab[%0d]", t, i), got_q[i],
                   tbl[t].ab[i]);
      end

      // Async reset during the third vector, then a fresh short run.
      and_mode = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = 1'b0; bus.n_vec = 4;
      @(negedge clk);
      bus.start = 1'b0;
      vcnt = 0;
      for (int c = 0; c < 40 && vcnt < 3; c++) begin
         @(negedge clk);
         if (bus.valid && bus.vec_count == 2) vcnt = 3;
      end
      chk("reached third vector", vcnt, 3);
      #2 rst = 1'b1;
      #1;
      chk("async reset outputs",
          {bus.a, bus.b, bus.valid, bus.busy, bus.done, bus.err}, 0);
      chk("async reset vec_count", bus.vec_count, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      run("restart", 0, 8'h00, 2, 0, 0);
      if (got_q.size() > 0) chk("restart first ab", got_q[0], 2'b00);
      chk("restart vec_count", bus.vec_count, 2);

      for (int r = 0; r < 8; r++)
         run($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
             8'($urandom), CNT_W'($urandom_range(1, 12)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
